ycbcr_buf_ctrl: RTL

Sequencing controller for the 3-plane YCbCr pixel buffer (1M x 32-bit per plane, auto-incrementing write/read counters, posedge write, negedge read).
- Runs one frame at a time: clear buffer counters, accept num_pix pixels from upstream via valid/ready, then stream them back out to downstream.
- Drives the buffer's enable/en_write/en_read; pixel data wires go directly between producer, buffer and consumer.

---
 rtl/ycbcr_buf_ctrl_if.sv | 29 ++
 rtl/ycbcr_buf_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/ycbcr_buf_ctrl_if.sv
// Handshake and buffer-strobe bundle between the YCbCr buffer controller and its frame source/sink.
interface ycbcr_buf_ctrl_if #(
  parameter int CNT_W = 21
);
  logic             start;
  logic [CNT_W-1:0] num_pix;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             mem_enable;
  logic             mem_en_write;
  logic             mem_en_read;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] pix_cnt;

  modport master (
    output start, num_pix, in_valid,
    input  in_ready, out_valid, mem_enable, mem_en_write, mem_en_read,
    input  busy, done, err, pix_cnt
  );

  modport slave (
    input  start, num_pix, in_valid,
    output in_ready, out_valid, mem_enable, mem_en_write, mem_en_read,
    output busy, done, err, pix_cnt
  );
endinterface

// File: rtl/ycbcr_buf_ctrl.sv
// Frame sequencer for the 3-plane YCbCr buffer: clear, write num_pix pixels, dummy read, read back.
// Optional write-stall timeout enabled by defining YCBCR_CTRL_TIMEOUT_EN.
module ycbcr_buf_ctrl #(
  parameter int CNT_W       = 21,
  parameter int MAX_PIX     = 1048576,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            clk,
  input  logic            rst,
  ycbcr_buf_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_PRIME = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  if (TIMEOUT_CYC < 1 || MAX_PIX < 1 || MAX_PIX >= 2**CNT_W) begin : g_param_check
    $error("ycbcr_buf_ctrl: inconsistent CNT_W/MAX_PIX/TIMEOUT_CYC");
  end

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  logic             len_ok;
  logic             last_q;

  assign len_ok = (bus.num_pix != '0) && (bus.num_pix <= CNT_W'(MAX_PIX));
  assign last_q = (cnt_q == (len_q - CNT_W'(1)));

`ifdef YCBCR_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] stall_q, stall_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    err_d   = err_q;
`ifdef YCBCR_CTRL_TIMEOUT_EN
    stall_d = stall_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (len_ok) begin
            len_d   = bus.num_pix;
            err_d   = 1'b0;
            state_d = S_CLEAR;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_WRITE;
`ifdef YCBCR_CTRL_TIMEOUT_EN
        stall_d = '0;
`endif
      end
      S_WRITE: begin
        if (bus.in_valid) begin
`ifdef YCBCR_CTRL_TIMEOUT_EN
          stall_d = '0;
`endif
          if (last_q) begin
            cnt_d   = '0;
            state_d = S_PRIME;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef YCBCR_CTRL_TIMEOUT_EN
        else if (stall_q == TO_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          stall_d = stall_q + TO_W'(1);
        end
`endif
      end
      // The dummy read consumes the buffer's all-ones read-counter slot.
      S_PRIME: state_d = S_READ;
      S_READ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (last_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
`ifdef YCBCR_CTRL_TIMEOUT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
`ifdef YCBCR_CTRL_TIMEOUT_EN
      stall_q <= stall_d;
`endif
    end
  end

  // Write strobe is combinational so it settles before the buffer's posedge write.
  assign bus.in_ready     = (state_q == S_WRITE);
  assign bus.mem_en_write = (state_q == S_WRITE) && bus.in_valid;
  assign bus.mem_en_read  = (state_q == S_PRIME) || (state_q == S_READ);
  assign bus.out_valid    = (state_q == S_READ);
  assign bus.mem_enable   = (state_q == S_WRITE) || (state_q == S_PRIME) ||
                            (state_q == S_READ)  || (state_q == S_DONE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.err          = err_q;
  assign bus.pix_cnt      = cnt_q;

endmodule
